// File: rtl/led_sequencer_core.sv
// led_sequencer_core: ROM-programmed sequencer driving peripheral write strobes and timed waits
module led_sequencer_core #(
  parameter int DATA_W = 8,
  parameter int ROM_DEPTH = 32,
  parameter int CNT_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          prog_we,
  input  logic [7:0]                    prog_addr,
  input  logic [DATA_W-1:0]             prog_data,
  output logic                          wr_en,
  output logic [7:0]                    data_address,
  output logic [DATA_W-1:0]             write_data,
  output logic [CNT_BYTES*DATA_W-1:0]   counter,
  output logic [7:0]                    pc,
  output logic                          busy,
  output logic                          halted,
  output logic                          err
);
  localparam int CW = CNT_BYTES * DATA_W;
  localparam int AW = ROM_DEPTH > 1 ? $clog2(ROM_DEPTH) : 1;
  localparam logic [DATA_W-1:0] OP_NOP  = DATA_W'(8'h11);
  localparam logic [DATA_W-1:0] OP_W1   = DATA_W'(8'h12);
  localparam logic [DATA_W-1:0] OP_W3   = DATA_W'(8'h14);
  localparam logic [DATA_W-1:0] OP_LD   = DATA_W'(8'h15);
  localparam logic [DATA_W-1:0] OP_WAIT = DATA_W'(8'h16);
  localparam logic [DATA_W-1:0] OP_JMP  = DATA_W'(8'h17);
  localparam logic [DATA_W-1:0] OP_HALT = DATA_W'(8'h18);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, OPERAND, WRITE, WAIT, HALT} state_t;
  state_t state, resume;
  logic [DATA_W-1:0] rom [ROM_DEPTH];
  logic [DATA_W-1:0] ir, rd;
  logic [7:0] ipc, pc_inc, bcnt;
  logic [CW-1:0] sh, sh_nxt;
  logic stop_pend, stopping;
  assign rd = rom[pc[AW-1:0]];
  assign pc_inc = int'(pc) == ROM_DEPTH - 1 ? 8'd0 : pc + 8'd1;
  assign sh_nxt = (sh << DATA_W) | CW'(rd);
  assign stopping = stop | stop_pend;
  assign resume = stopping ? IDLE : FETCH;
  assign busy = state != IDLE && state != HALT;
  assign halted = state == HALT;
  always_ff @(posedge clk)
    if (prog_we && !busy && int'(prog_addr) < ROM_DEPTH) rom[prog_addr[AW-1:0]] <= prog_data;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc <= '0;
      ipc <= '0;
      ir <= '0;
      bcnt <= '0;
      sh <= '0;
      wr_en <= 1'b0;
      data_address <= '0;
      write_data <= '0;
      counter <= '0;
      err <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      stop_pend <= busy && stopping;
      case (state)
        IDLE, HALT: if (start && !stop) begin
          pc <= '0;
          err <= 1'b0;
          state <= FETCH;
        end
        FETCH: begin
          ir <= rd;
          ipc <= pc;
          state <= DECODE;
        end
        DECODE: begin
          pc <= pc_inc;
          bcnt <= '0;
          sh <= '0;
          if (ir == OP_NOP) state <= resume;
          else if (ir >= OP_W1 && ir <= OP_W3) begin
            data_address <= 8'(ir - OP_NOP);
            state <= OPERAND;
          end else if (ir == OP_LD || ir == OP_JMP) state <= OPERAND;
          else if (ir == OP_WAIT) state <= WAIT;
          else begin
            pc <= pc;
            if (ir != OP_HALT) err <= 1'b1;
            state <= HALT;
          end
        end
        OPERAND: begin
          pc <= pc_inc;
          if (ir == OP_JMP) begin
            // an out-of-range target parks pc on the offending JMP
            if (int'(rd) >= ROM_DEPTH) begin
              pc <= ipc;
              err <= 1'b1;
              state <= HALT;
            end else begin
              pc <= 8'(rd);
              state <= resume;
            end
          end else if (ir == OP_LD) begin
            sh <= sh_nxt;
            bcnt <= bcnt + 8'd1;
            if (int'(bcnt) == CNT_BYTES - 1) begin
              counter <= sh_nxt;
              state <= resume;
            end
          end else begin
            write_data <= rd;
            wr_en <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE: state <= resume;
        WAIT: if (stopping) state <= IDLE;
          else if (counter == '0) state <= FETCH;
          else counter <= counter - CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_sequencer_core.sv
// tb_led_sequencer_core: directed programs with a write-strobe scoreboard and state checks
module tb_led_sequencer_core;
  logic clk = 0, rst = 0, start = 0, stop = 0, prog_we = 0;
  logic [7:0] prog_addr = 0, prog_data = 0;
  logic wr_en, busy, halted, err;
  logic [7:0] data_address, write_data, pc;
  logic [31:0] counter;
  int checks = 0, errors = 0, cyc = 0, last_cyc = 0;
  typedef struct {logic [7:0] a; logic [7:0] d; int gap;} wr_t;
  wr_t q[$];
  logic [7:0] pv [12];

  led_sequencer_core #(.DATA_W(8), .ROM_DEPTH(32), .CNT_BYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .wr_en(wr_en), .data_address(data_address), .write_data(write_data),
    .counter(counter), .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst && wr_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected actual=%0h/%0h expected=none", data_address, write_data);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr_data", {data_address, write_data}, {e.a, e.d});
        if (e.gap != 0) chk("wr_gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    prog_we = 1;
    prog_addr = a;
    prog_data = d;
    tick(1);
    prog_we = 0;
  endtask

  task automatic load_prog(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) load(8'(base + i), pv[i]);
  endtask

  task automatic go();
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      tick(1);
      n++;
    end
    chk({name, "_done"}, busy, 0);
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [7:0] d, input int gap);
    wr_t e;
    e.a = a;
    e.d = d;
    e.gap = gap;
    q.push_back(e);
  endtask

  initial begin
    tick(2);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_counter", counter, 0);
    rst = 1;
    tick(2);
    pv = '{8'h12, 8'h05, 8'h13, 8'h05, 8'h14, 8'h03, 8'h18, 0, 0, 0, 0, 0};
    load_prog(0, 7);
    expect_wr(1, 8'h05, 0);
    expect_wr(2, 8'h05, 4);
    expect_wr(3, 8'h03, 4);
    go();
    wait_idle("writes");
    chk("writes_halted", halted, 1);
    chk("writes_pc", pc, 6);
    chk("writes_err", err, 0);
    pv = '{8'h15, 8'h00, 8'h00, 8'h00, 8'h05, 8'h16, 8'h18, 0, 0, 0, 0, 0};
    load_prog(0, 7);
    go();
    tick(5);
    chk("ld_not_yet", counter, 0);
    tick(1);
    chk("ld_counter", counter, 5);
    tick(2);
    chk("wait_5", counter, 5);
    for (int k = 4; k >= 0; k--) begin
      tick(1);
      chk("wait_count", counter, k);
    end
    wait_idle("wait");
    chk("wait_halted", halted, 1);
    chk("wait_end_cnt", counter, 0);
    chk("wait_pc", pc, 6);
    load(0, 8'h17);
    load(1, 8'h1F);
    load(31, 8'h18);
    go();
    wait_idle("jmp");
    chk("jmp_pc", pc, 31);
    chk("jmp_err", err, 0);
    load(1, 8'h40);
    go();
    wait_idle("jmp_bad");
    chk("jmp_bad_err", err, 1);
    chk("jmp_bad_halted", halted, 1);
    chk("jmp_bad_pc", pc, 0);
    pv = '{8'h11, 8'h11, 8'h11, 8'h99, 0, 0, 0, 0, 0, 0, 0, 0};
    load_prog(0, 4);
    go();
    wait_idle("undef");
    chk("undef_err", err, 1);
    chk("undef_halted", halted, 1);
    chk("undef_pc", pc, 3);
    go();
    chk("restart_err_clr", err, 0);
    wait_idle("undef2");
    pv = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h18, 0, 0, 0};
    load_prog(0, 9);
    load(40, 8'h99);
    go();
    wait_idle("drop");
    chk("drop_pc", pc, 8);
    chk("drop_err", err, 0);
    pv = '{8'h15, 8'h00, 8'h00, 8'h00, 8'h14, 8'h16, 8'h12, 8'h77, 8'h18, 0, 0, 0};
    load_prog(0, 9);
    expect_wr(1, 8'h77, 0);
    go();
    tick(10);
    prog_we = 1;
    prog_addr = 7;
    prog_data = 8'h55;
    start = 1;
    tick(1);
    prog_we = 0;
    start = 0;
    wait_idle("busy_we");
    chk("busy_we_pc", pc, 8);
    load(30, 8'h15);
    load(31, 8'h00);
    pv = '{8'h17, 8'h1E, 8'h03, 8'h18, 0, 0, 0, 0, 0, 0, 0, 0};
    load_prog(0, 4);
    go();
    wait_idle("ld_wrap");
    chk("ld_wrap_cnt", counter, 32'h00171E03);
    chk("ld_wrap_pc", pc, 3);
    pv = '{8'h15, 8'h00, 8'h00, 8'h00, 8'h64, 8'h16, 8'h18, 0, 0, 0, 0, 0};
    load_prog(0, 7);
    go();
    tick(18);
    chk("stop_pre_cnt", counter, 90);
    stop = 1;
    tick(1);
    stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_halted", halted, 0);
    chk("stop_cnt", counter, 90);
    pv = '{8'h12, 8'h5A, 8'h13, 8'h66, 8'h18, 0, 0, 0, 0, 0, 0, 0};
    load_prog(0, 5);
    expect_wr(1, 8'h5A, 0);
    go();
    tick(1);
    stop = 1;
    tick(1);
    stop = 0;
    wait_idle("stop_wr");
    chk("stop_wr_halted", halted, 0);
    chk("stop_wr_pc", pc, 2);
    start = 1;
    stop = 1;
    tick(1);
    start = 0;
    stop = 0;
    chk("stop_prio", busy, 0);
    pv = '{8'h12, 8'hA5, 8'h18, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_prog(0, 3);
    go();
    tick(3);
    rst = 0;
    #1;
    chk("rstw_wr_en", wr_en, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_addr", data_address, 0);
    chk("rstw_data", write_data, 0);
    chk("rstw_counter", counter, 0);
    chk("rstw_pc", pc, 0);
    tick(1);
    rst = 1;
    tick(3);
    chk("rst_stays_idle", busy, 0);
    expect_wr(1, 8'hA5, 0);
    go();
    wait_idle("rom_kept");
    chk("rom_kept_pc", pc, 2);
    chk("rom_kept_halted", halted, 1);
    tick(2);
    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_sequencer_core.md
LED_SEQUENCER_CORE -- requirements
Module: led_sequencer_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: ROM word, operand and write_data width.
REQ-002 SHALL have parameter ROM_DEPTH, default 32: program ROM words, legal range 4..256.
REQ-003 SHALL have parameter CNT_BYTES, default 4: LOADCNT operand byte count; counter width is CNT_BYTES*DATA_W.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: start  in  1  launch program at address 0 when idle/halted; stop  in  1  abort request.
REQ-006 SHALL have ports: prog_we  in  1, prog_addr  in  8, prog_data  in  DATA_W  program-load write port.
REQ-007 SHALL have ports: wr_en  out  1  one-cycle peripheral write strobe; data_address  out  8; write_data  out  DATA_W.
REQ-008 SHALL have ports: counter  out  CNT_BYTES*DATA_W  delay register; pc  out  8  fetch address.
REQ-009 SHALL have ports: busy  out  1; halted  out  1; err  out  1  sticky illegal-opcode/jump flag.

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, OPERAND, WRITE, WAIT, HALT; each ROM read costs one cycle.
REQ-011 SHALL in IDLE/HALT on start=1 set pc=0, clear err, go to FETCH; busy=1 in every state except IDLE/HALT.
REQ-012 SHALL accept prog_we only when busy=0 and prog_addr<ROM_DEPTH; otherwise the write is dropped.
REQ-013 SHALL decode opcodes: 0x11 NOP; 0x12/0x13/0x14 WRITE to address 1/2/3; 0x15 LOADCNT; 0x16 WAIT; 0x17 JMP; 0x18 HALT.
REQ-014 SHALL execute NOP in 2 cycles (FETCH, DECODE), pc+1.
REQ-015 SHALL execute WRITE in 4 cycles: DECODE sets data_address; OPERAND reads data byte; WRITE drives write_data and wr_en=1 for exactly one cycle; pc advances 2.
REQ-016 SHALL keep wr_en=0 in every state other than WRITE.
REQ-017 SHALL execute LOADCNT in 2+CNT_BYTES cycles, bytes big-endian (first byte MSB), counter updated atomically on last operand cycle; pc advances 1+CNT_BYTES.
REQ-018 SHALL in WAIT decrement counter by 1 per cycle and return to FETCH on the cycle counter reads 0; WAIT with counter=0 costs 1 WAIT cycle; counter ends at 0.
REQ-019 SHALL execute JMP in 3 cycles, pc=operand; operand>=ROM_DEPTH sets err=1 and goes to HALT.
REQ-020 SHALL on HALT opcode go to HALT, halted=1, pc holds address of HALT opcode.
REQ-021 SHALL on undefined opcode set err=1, go to HALT, pc holds offending address.
REQ-022 SHALL wrap pc from ROM_DEPTH-1 to 0, including mid-operand reads (modulo ROM_DEPTH).
REQ-023 SHALL on stop=1 finish the current instruction (including a pending wr_en pulse) then go to IDLE instead of FETCH; stop during WAIT aborts the wait immediately, counter holds.
REQ-024 SHALL give stop priority over start when both asserted in the same cycle.
REQ-025 SHALL ignore start while busy=1.

Reset
REQ-026 SHALL on rst=0, asynchronously: state=IDLE, pc=0, wr_en=0, data_address=0, write_data=0, counter=0, busy=0, halted=0, err=0.
REQ-027 SHALL preserve ROM contents across reset; reset mid-instruction produces no wr_en pulse.
REQ-028 SHALL leave IDLE only on start after rst returns high.

Verification
REQ-029 Program {12,05,13,05,14,03,18}, start -> wr_en pulses at (addr1,05),(addr2,05),(addr3,03), each 4 cycles apart, then halted=1, pc=6.
REQ-030 Program {15,00,00,00,05,16,18}, start -> counter=0x00000005 after 6 cycles, counts 5..0 in WAIT, halted=1 with counter=0.
REQ-031 Program {17,1F,...} ROM_DEPTH=32 -> jump to 31; program {17,40} -> err=1, halted=1, pc=0.
REQ-032 Opcode 0x99 at address 3 -> err=1, halted=1, pc=3, no wr_en; next start clears err.
REQ-033 WAIT with counter=100, stop at cycle 10 -> IDLE next cycle, counter=90; rst=0 during WRITE state -> wr_en=0 immediately, all outputs reset values.
REQ-034 prog_we while busy=1 -> ROM unchanged; LOADCNT placed at address 30 of 32 -> operand bytes read from 31,0,1,2.
